add8_err_monitor: RTL and testbench

ADD8_ERR_MONITOR -- requirements
Module: add8_err_monitor

---
 rtl/add8_err_monitor.sv | 192 +++++++++++++++++++
 tb/tb_add8_err_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_err_monitor.sv
// Error-metric monitor for an 8-bit adder under test: accumulates sample count, error count,
// sum of absolute errors, sum of Hamming distances and worst-case error over a run.
module add8_err_monitor #(
  parameter int unsigned CNT_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [7:0]         A,
  input  logic [7:0]         B,
  input  logic [8:0]         O,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_samples,
  output logic [CNT_W-1:0]   res_err_cnt,
  output logic [CNT_W+8:0]   res_sum_abs,
  output logic [CNT_W+3:0]   res_sum_hd,
  output logic [8:0]         res_wce,
  output logic               res_sat,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             drain_cnt_q, drain_cnt_d;

  logic             s1_valid_q, s1_valid_d;
  logic [8:0]       s1_abs_q, s1_abs_d;
  logic [3:0]       s1_hd_q, s1_hd_d;
  logic             s1_nz_q, s1_nz_d;

  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W+8:0] sum_abs_q, sum_abs_d;
  logic [CNT_W+3:0] sum_hd_q, sum_hd_d;
  logic [8:0]       wce_q, wce_d;
  logic             sat_q, sat_d;

  logic             hs;
  logic [8:0]       exact;
  logic [8:0]       diff_bits;

  logic [CNT_W:0]   samples_sum;
  logic [CNT_W:0]   err_cnt_sum;
  logic [CNT_W+9:0] sum_abs_sum;
  logic [CNT_W+4:0] sum_hd_sum;

  assign in_ready  = (state_q == ST_RUN);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign hs        = in_valid && in_ready;

  assign res_samples = samples_q;
  assign res_err_cnt = err_cnt_q;
  assign res_sum_abs = sum_abs_q;
  assign res_sum_hd  = sum_hd_q;
  assign res_wce     = wce_q;
  assign res_sat     = sat_q;

  // Stage 1 metrics, computed from the handshaked sample and registered on that edge.
  always_comb begin
    exact     = {1'b0, A} + {1'b0, B};
    diff_bits = O ^ exact;
    s1_valid_d = hs;
    s1_abs_d   = (O >= exact) ? (O - exact) : (exact - O);
    s1_nz_d    = (O != exact);
    s1_hd_d    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      s1_hd_d = s1_hd_d + {3'b000, diff_bits[i]};
    end
  end

  // Widened sums; the extra top bit flags an add that must clip to all-ones.
  always_comb begin
    samples_sum = {1'b0, samples_q} + (CNT_W + 1)'(1);
    err_cnt_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(s1_nz_q);
    sum_abs_sum = {1'b0, sum_abs_q} + (CNT_W + 10)'(s1_abs_q);
    sum_hd_sum  = {1'b0, sum_hd_q} + (CNT_W + 5)'(s1_hd_q);
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    samples_d   = samples_q;
    err_cnt_d   = err_cnt_q;
    sum_abs_d   = sum_abs_q;
    sum_hd_d    = sum_hd_q;
    wce_d       = wce_q;
    sat_d       = sat_q;

    // Stage 2: fold the registered metrics into the saturating accumulators.
    if (s1_valid_q && busy) begin
      if (samples_sum[CNT_W]) begin
        samples_d = '1;
        sat_d     = 1'b1;
      end else begin
        samples_d = samples_sum[CNT_W-1:0];
      end
      if (err_cnt_sum[CNT_W]) begin
        err_cnt_d = '1;
        sat_d     = 1'b1;
      end else begin
        err_cnt_d = err_cnt_sum[CNT_W-1:0];
      end
      if (sum_abs_sum[CNT_W+9]) begin
        sum_abs_d = '1;
        sat_d     = 1'b1;
      end else begin
        sum_abs_d = sum_abs_sum[CNT_W+8:0];
      end
      if (sum_hd_sum[CNT_W+4]) begin
        sum_hd_d = '1;
        sat_d    = 1'b1;
      end else begin
        sum_hd_d = sum_hd_sum[CNT_W+3:0];
      end
      if (s1_abs_q > wce_q) begin
        wce_d = s1_abs_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          samples_d = '0;
          err_cnt_d = '0;
          sum_abs_d = '0;
          sum_hd_d  = '0;
          wce_d     = '0;
          sat_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (hs && in_last) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_abs_q    <= '0;
      s1_hd_q     <= '0;
      s1_nz_q     <= 1'b0;
      samples_q   <= '0;
      err_cnt_q   <= '0;
      sum_abs_q   <= '0;
      sum_hd_q    <= '0;
      wce_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_abs_q    <= s1_abs_d;
      s1_hd_q     <= s1_hd_d;
      s1_nz_q     <= s1_nz_d;
      samples_q   <= samples_d;
      err_cnt_q   <= err_cnt_d;
      sum_abs_q   <= sum_abs_d;
      sum_hd_q    <= sum_hd_d;
      wce_q       <= wce_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: default-width instance plus a CNT_W=4 instance for clipping.
module tb_add8_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_last, res_ready;
  logic [7:0]  A, B;
  logic [8:0]  O;
  logic        in_ready, res_valid, res_sat, busy;
  logic [16:0] res_samples, res_err_cnt;
  logic [25:0] res_sum_abs;
  logic [20:0] res_sum_hd;
  logic [8:0]  res_wce;

  logic        s_start, s_in_valid, s_in_last, s_res_ready;
  logic [7:0]  s_a, s_b;
  logic [8:0]  s_o;
  logic        s_in_ready, s_res_valid, s_res_sat, s_busy;
  logic [3:0]  s_res_samples, s_res_err_cnt;
  logic [12:0] s_res_sum_abs;
  logic [7:0]  s_res_sum_hd;
  logic [8:0]  s_res_wce;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add8_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .A(A), .B(B), .O(O), .res_valid(res_valid), .res_ready(res_ready),
    .res_samples(res_samples), .res_err_cnt(res_err_cnt), .res_sum_abs(res_sum_abs),
    .res_sum_hd(res_sum_hd), .res_wce(res_wce), .res_sat(res_sat), .busy(busy)
  );

  add8_err_monitor #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_last(s_in_last), .A(s_a), .B(s_b), .O(s_o), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_samples(s_res_samples), .res_err_cnt(s_res_err_cnt),
    .res_sum_abs(s_res_sum_abs), .res_sum_hd(s_res_sum_hd), .res_wce(s_res_wce),
    .res_sat(s_res_sat), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o,
                      input logic last);
    A = a; B = b; O = o; in_last = last; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!res_valid && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_done: res_valid=%b after %0d cycles, required 1", res_valid, n);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_samples !== 17'd0 ||
        res_wce !== 9'd0 || res_sat !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b busy=%b samples=%0d wce=%0d sat=%b, required all 0",
               in_ready, res_valid, busy, res_samples, res_wce, res_sat);
    end
  endtask

  task automatic test_exact();
    do_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL exact_run_entry: in_ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    send(8'd200, 8'd100, 9'd300, 1'b1);
    wait_done(6);
    checks++;
    if (res_samples !== 17'd1 || res_err_cnt !== 17'd0 || res_sum_abs !== 26'd0 ||
        res_sum_hd !== 21'd0 || res_wce !== 9'd0 || res_sat !== 1'b0) begin
      failures++;
      $display("FAIL exact: samples=%0d err=%0d abs=%0d hd=%0d wce=%0d sat=%b, required 1 0 0 0 0 0",
               res_samples, res_err_cnt, res_sum_abs, res_sum_hd, res_wce, res_sat);
    end
    consume();
  endtask

  task automatic test_approx();
    do_start();
    send(8'd200, 8'd100, 9'd297, 1'b1);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL approx_drain1: valid=%b ready=%b busy=%b, required 0 0 1",
               res_valid, in_ready, busy);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL approx_drain2: valid=%b busy=%b, required 0 1", res_valid, busy);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL approx_latency: valid=%b busy=%b, required 1 0", res_valid, busy);
    end
    checks++;
    if (res_samples !== 17'd1 || res_err_cnt !== 17'd1 || res_sum_abs !== 26'd3 ||
        res_sum_hd !== 21'd2 || res_wce !== 9'd3 || res_sat !== 1'b0) begin
      failures++;
      $display("FAIL approx: samples=%0d err=%0d abs=%0d hd=%0d wce=%0d sat=%b, required 1 1 3 2 3 0",
               res_samples, res_err_cnt, res_sum_abs, res_sum_hd, res_wce, res_sat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    do_start();
    if (!in_ready) gaps++;
    send(8'd10, 8'd5, 9'd15, 1'b0);
    if (!in_ready) gaps++;
    send(8'd255, 8'd255, 9'd0, 1'b0);
    if (!in_ready) gaps++;
    start = 1'b1;  // must be ignored while running
    send(8'd1, 8'd2, 9'd7, 1'b0);
    start = 1'b0;
    if (!in_ready) gaps++;
    send(8'd128, 8'd0, 9'd129, 1'b1);
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL b2b_gaps: gaps=%0d, required 0", gaps);
    end
    wait_done(6);
    checks++;
    if (res_samples !== 17'd4 || res_err_cnt !== 17'd3 || res_sum_abs !== 26'd515 ||
        res_sum_hd !== 21'd10 || res_wce !== 9'd510 || res_sat !== 1'b0) begin
      failures++;
      $display("FAIL b2b: samples=%0d err=%0d abs=%0d hd=%0d wce=%0d sat=%b, required 4 3 515 10 510 0",
               res_samples, res_err_cnt, res_sum_abs, res_sum_hd, res_wce, res_sat);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (res_valid !== 1'b1 || res_samples !== 17'd4 || res_err_cnt !== 17'd3 ||
          res_sum_abs !== 26'd515 || res_sum_hd !== 21'd10 || res_wce !== 9'd510) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure: unstable cycles=%0d, required 0", bad);
    end
    consume();
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_samples !== 17'd4 || res_wce !== 9'd510) begin
      failures++;
      $display("FAIL idle_hold: valid=%b busy=%b samples=%0d wce=%0d, required 0 0 4 510",
               res_valid, busy, res_samples, res_wce);
    end
  endtask

  task automatic test_start_with_valid();
    A = 8'd1; B = 8'd1; O = 9'd0; in_last = 1'b1; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || res_samples !== 17'd0 || res_wce !== 9'd0) begin
      failures++;
      $display("FAIL new_run_clear: ready=%b samples=%0d wce=%0d, required 1 0 0",
               in_ready, res_samples, res_wce);
    end
    tick(); tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || res_samples !== 17'd0 || res_err_cnt !== 17'd0) begin
      failures++;
      $display("FAIL start_valid_ignored: ready=%b samples=%0d err=%0d, required 1 0 0",
               in_ready, res_samples, res_err_cnt);
    end
    send(8'd0, 8'd0, 9'd0, 1'b1);
    wait_done(6);
    checks++;
    if (res_samples !== 17'd1 || res_err_cnt !== 17'd0 || res_sum_abs !== 26'd0) begin
      failures++;
      $display("FAIL single_last: samples=%0d err=%0d abs=%0d, required 1 0 0",
               res_samples, res_err_cnt, res_sum_abs);
    end
    consume();
  endtask

  task automatic test_exhaustive();
    int gaps = 0;
    do_start();
    for (int i = 0; i < 65536; i++) begin
      if (!in_ready) gaps++;
      A = i[7:0];
      B = i[15:8];
      O = {1'b0, A} + {1'b0, B};
      in_last = (i == 65535);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL exhaustive_gaps: gaps=%0d, required 0", gaps);
    end
    wait_done(6);
    checks++;
    if (res_samples !== 17'd65536 || res_err_cnt !== 17'd0 || res_sum_abs !== 26'd0 ||
        res_sum_hd !== 21'd0 || res_wce !== 9'd0 || res_sat !== 1'b0) begin
      failures++;
      $display("FAIL exhaustive: samples=%0d err=%0d abs=%0d hd=%0d wce=%0d sat=%b, required 65536 0 0 0 0 0",
               res_samples, res_err_cnt, res_sum_abs, res_sum_hd, res_wce, res_sat);
    end
    consume();
  endtask

  task automatic test_saturation();
    int n = 0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_a = 8'(i); s_b = 8'd0; s_o = 9'(i + 1);
      s_in_last = (i == 19);
      s_in_valid = 1'b1;
      tick();
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    while (!s_res_valid && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (s_res_valid !== 1'b1 || s_res_samples !== 4'd15 || s_res_err_cnt !== 4'd15 ||
        s_res_sum_abs !== 13'd20 || s_res_wce !== 9'd1 || s_res_sat !== 1'b1) begin
      failures++;
      $display("FAIL saturation: valid=%b samples=%0d err=%0d abs=%0d wce=%0d sat=%b, required 1 15 15 20 1 1",
               s_res_valid, s_res_samples, s_res_err_cnt, s_res_sum_abs, s_res_wce, s_res_sat);
    end
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_start();
    for (int i = 0; i < 5; i++) begin
      send(8'(i), 8'd0, 9'(i + 3), 1'b0);
    end
    // rst wins over a concurrent handshake, start and res_ready
    rst = 1'b1; start = 1'b1; res_ready = 1'b1;
    A = 8'd0; B = 8'd0; O = 9'd100; in_valid = 1'b1; in_last = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; res_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_samples !== 17'd0 ||
        res_err_cnt !== 17'd0 || res_sum_abs !== 26'd0 || res_sum_hd !== 21'd0 ||
        res_wce !== 9'd0 || res_sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: ready=%b valid=%b busy=%b samples=%0d err=%0d abs=%0d wce=%0d",
               in_ready, res_valid, busy, res_samples, res_err_cnt, res_sum_abs, res_wce);
    end
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || res_samples !== 17'd0 || res_err_cnt !== 17'd0 ||
        res_sum_abs !== 26'd0 || res_sum_hd !== 21'd0 || res_wce !== 9'd0) begin
      failures++;
      $display("FAIL reset_flush: busy=%b samples=%0d err=%0d abs=%0d hd=%0d wce=%0d, required 0",
               busy, res_samples, res_err_cnt, res_sum_abs, res_sum_hd, res_wce);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    A = '0; B = '0; O = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_res_ready = 1'b0;
    s_a = '0; s_b = '0; s_o = '0;
    #1;
    test_reset();
    test_exact();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_start_with_valid();
    test_saturation();
    test_exhaustive();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
